// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types and constants for the SPI command receiver
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } rx_state_e;

    localparam logic [3:0] DEV_MODE     = 4'd0;
    localparam logic [3:0] DEV_DDS_RAM  = 4'd1;
    localparam logic [3:0] DEV_DDS_CODE = 4'd2;
    localparam logic [3:0] DEV_READ     = 4'd8;

    localparam logic [7:0] MODE_NONE = 8'd0;
    localparam logic [7:0] MODE_DDS  = 8'd1;

    localparam int         DEFAULT_FRAME_BITS = 36;
    localparam logic [5:0] CMD_LEN_MAX        = 6'd63;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - STAGES-deep synchronizer for one asynchronous input
module sync_2ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_cmd_receiver.sv
// rtl/spi_cmd_receiver.sv - SPI mode-0 command frame receiver with response shifter
// Optional frame length checking with len_err output: SPI_CMD_LEN_CHECK_EN.
module spi_cmd_receiver
    import spi_cmd_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int ID_BITS     = 4,
    parameter int RSP_BITS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          sclk,
    input  logic                          ncs,
    input  logic                          di,
    output logic                          dout,
    input  logic [RSP_BITS-1:0]           rsp_data,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [ID_BITS-1:0]            cmd_id,
    output logic [FRAME_BITS-ID_BITS-1:0] cmd_data,
    output logic [5:0]                    cmd_len,
    output logic                          cmd_overflow,
`ifdef SPI_CMD_LEN_CHECK_EN
    output logic                          len_err,
`endif
    output logic                          busy
);

    localparam int              WCNT_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [WCNT_W-1:0] WAIT_CNT = WCNT_W'(SYNC_STAGES);

    logic ncs_s, sclk_s, di_s;
    logic ncs_q, sclk_q;
    logic ncs_fall, ncs_rise, sclk_rise, sclk_fall;

    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .nreset(nreset), .d(ncs), .q(ncs_s)
    );
    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .nreset(nreset), .d(sclk), .q(sclk_s)
    );
    sync_2ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_di (
        .clk(clk), .nreset(nreset), .d(di), .q(di_s)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ncs_q  <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            ncs_q  <= ncs_s;
            sclk_q <= sclk_s;
        end
    end

    assign ncs_fall  = ncs_q & ~ncs_s;
    assign ncs_rise  = ~ncs_q & ncs_s;
    assign sclk_rise = ~sclk_q & sclk_s;
    assign sclk_fall = sclk_q & ~sclk_s;

    rx_state_e         state, state_next;
    logic [WCNT_W-1:0] idle_cnt;

    // The ncs chain resets to 1, so ncs must read high for SYNC_STAGES cycles of
    // real pin samples before leaving WAIT_IDLE; otherwise a held-low ncs looks idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idle_cnt <= '0;
        end else if (state == WAIT_IDLE && ncs_s) begin
            if (idle_cnt != WAIT_CNT) idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= WAIT_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (ncs_s && idle_cnt == WAIT_CNT) state_next = IDLE;
            IDLE:      if (ncs_fall) state_next = ACTIVE;
            ACTIVE:    if (ncs_rise) state_next = IDLE;
            default:   state_next = WAIT_IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] shift_reg;
    logic [5:0]            bitcnt;
    logic [RSP_BITS-1:0]   rsp_shift;
    logic                  frame_start, frame_end, len_bad, deliver;

    assign frame_start = (state == IDLE) && ncs_fall;
    assign frame_end   = (state == ACTIVE) && ncs_rise;

    // A bit clocked in on the same cycle as the ncs fall lands after the clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift_reg <= '0;
            bitcnt    <= '0;
            rsp_shift <= '0;
        end else if (frame_start) begin
            shift_reg <= sclk_rise ? {{(FRAME_BITS-1){1'b0}}, di_s} : '0;
            bitcnt    <= sclk_rise ? 6'd1 : 6'd0;
            rsp_shift <= rsp_data;
        end else if (state == ACTIVE && !ncs_s) begin
            if (sclk_rise) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], di_s};
                if (bitcnt != CMD_LEN_MAX) bitcnt <= bitcnt + 6'd1;
            end
            if (sclk_fall) rsp_shift <= {rsp_shift[RSP_BITS-2:0], 1'b0};
        end
    end

`ifdef SPI_CMD_LEN_CHECK_EN
    assign len_bad = (bitcnt != 6'd0) && (bitcnt != 6'(FRAME_BITS));
`else
    assign len_bad = 1'b0;
`endif
    assign deliver = frame_end && (bitcnt != 6'd0) && !len_bad;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmd_valid    <= 1'b0;
            cmd_id       <= '0;
            cmd_data     <= '0;
            cmd_len      <= '0;
            cmd_overflow <= 1'b0;
        end else begin
            cmd_overflow <= 1'b0;
            if (deliver && cmd_valid && !cmd_ready) begin
                cmd_overflow <= 1'b1;
            end else if (deliver) begin
                cmd_valid <= 1'b1;
                cmd_id    <= shift_reg[ID_BITS-1:0];
                cmd_data  <= shift_reg[FRAME_BITS-1:ID_BITS];
                cmd_len   <= bitcnt;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_CMD_LEN_CHECK_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) len_err <= 1'b0;
        else         len_err <= frame_end && len_bad;
    end
`endif

    assign busy = (state == ACTIVE);
    assign dout = busy ? rsp_shift[RSP_BITS-1] : 1'b1;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// tb/tb_spi_cmd_receiver.sv - self-checking bench for spi_cmd_receiver with a frame-level model
module tb_spi_cmd_receiver;

    localparam int HP = 5;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        sclk = 1'b0;
    logic        ncs = 1'b1;
    logic        di = 1'b0;
    logic        dout;
    logic [31:0] rsp_data = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_len;
    logic        cmd_overflow;
    logic        busy;
`ifdef SPI_CMD_LEN_CHECK_EN
    logic        len_err;
`endif

    spi_cmd_receiver dut (
        .clk(clk), .nreset(nreset), .sclk(sclk), .ncs(ncs), .di(di), .dout(dout),
        .rsp_data(rsp_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_id(cmd_id), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .cmd_overflow(cmd_overflow),
`ifdef SPI_CMD_LEN_CHECK_EN
        .len_err(len_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    bit          chk_en = 1'b0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_id = '0;
    logic [31:0] m_data = '0;
    logic [5:0]  m_len = '0;
    int          exp_ovf = 0;
    int          ovf_seen = 0;
    int          exp_lenerr = 0;
    int          lenerr_seen = 0;
    logic [31:0] do_got;
    logic        dummy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (cmd_overflow) ovf_seen++;
`ifdef SPI_CMD_LEN_CHECK_EN
        if (len_err) lenerr_seen++;
`endif
        if (chk_en) begin
            chk("hold_valid", 64'(cmd_valid), 64'(m_valid));
            if (m_valid)
                chk("hold_word", 64'({cmd_id, cmd_data, cmd_len}), 64'({m_id, m_data, m_len}));
        end
    end

    // Frame-level expectation: the last 36 bits sent, right aligned, length clamped at 63.
    task automatic model_frame_end(input logic [127:0] bits, input int n, input bit ready_end);
        logic [35:0] v;
        v = bits[35:0];
        if (n < 36) v = v & ((36'd1 << n) - 36'd1);
        if (n == 0) begin
        end
`ifdef SPI_CMD_LEN_CHECK_EN
        else if (n != 36) exp_lenerr++;
`endif
        else if (m_valid && !ready_end) exp_ovf++;
        else begin
            m_valid = 1'b1;
            m_id    = v[3:0];
            m_data  = v[35:4];
            m_len   = (n > 63) ? 6'd63 : 6'(n);
        end
    endtask

    task automatic clock_bit(input logic b, output logic sampled);
        di = b;
        wclk(HP);
        sampled = dout;
        sclk = 1'b1;
        wclk(HP);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] bits, input int n, input logic [31:0] rsp,
                              input bit ready_end);
        logic s;
        do_got = '0;
        rsp_data = rsp;
        @(negedge clk);
        ncs = 1'b0;
        wclk(6);
        for (int i = 0; i < n; i++) begin
            clock_bit(bits[n-1-i], s);
            if (i < 32) do_got = {do_got[30:0], s};
            if (i == 0) chk("busy_in_frame", 64'(busy), 64'd1);
        end
        wclk(HP);
        ncs = 1'b1;
        chk_en = 1'b0;
        if (ready_end) begin
            wclk(2);
            cmd_ready = 1'b1;
            wclk(1);
            cmd_ready = 1'b0;
            wclk(6);
        end else begin
            wclk(9);
        end
        model_frame_end(bits, n, ready_end);
        chk_en = 1'b1;
        chk("ovf_count", 64'(ovf_seen), 64'(exp_ovf));
        chk("lenerr_count", 64'(lenerr_seen), 64'(exp_lenerr));
        chk("busy_idle", 64'(busy), 64'd0);
        chk("do_idle", 64'(dout), 64'd1);
    endtask

    task automatic accept_cmd();
        @(negedge clk);
        cmd_ready = 1'b1;
        m_valid = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    initial begin
        wclk(3);
        chk("rst_do", 64'(dout), 64'd1);
        chk("rst_outputs", 64'({cmd_valid, cmd_id, cmd_data, cmd_len, cmd_overflow, busy}), 64'd0);
        nreset = 1'b1;
        wclk(5);
        chk_en = 1'b1;

        // 36-bit frame held with cmd_ready low
        send_frame(128'h2_1234_5672, 36, 32'h0, 1'b0);
        wclk(20);
        chk("t1_word", 64'({cmd_valid, cmd_id, cmd_data, cmd_len}), 64'({1'b1, 4'h2, 32'h21234567, 6'd36}));

        // second frame dropped while first is pending
        send_frame(128'h3_DEAD_BEEF, 36, 32'h0, 1'b0);
        chk("t3_overflow_once", 64'(ovf_seen), 64'd1);
        chk("t3_first_held", 64'({cmd_valid, cmd_id, cmd_data}), 64'({1'b1, 4'h2, 32'h21234567}));

        // frame ending on the acceptance cycle replaces the pending one
        send_frame(128'h0_0000_0018, 36, 32'h0, 1'b1);
        chk("t3_same_cycle_load", 64'({cmd_valid, cmd_id, cmd_data}), 64'({1'b1, 4'h8, 32'h1}));
        chk("t3_no_new_overflow", 64'(ovf_seen), 64'd1);
        accept_cmd();
        wclk(2);
        chk("accept_drops_valid", 64'(cmd_valid), 64'd0);

        // response shift-out
        send_frame(128'h1234_5678, 32, 32'hA500_0001, 1'b0);
        chk("t2_do_word", 64'(do_got), 64'hA500_0001);
        if (m_valid) accept_cmd();

        // short frame
        send_frame(128'h010, 12, 32'h0, 1'b0);
`ifdef SPI_CMD_LEN_CHECK_EN
        chk("t4_len_err", 64'({cmd_valid, 6'(lenerr_seen)}), 64'({1'b0, 6'd2}));
`else
        chk("t4_short", 64'({cmd_valid, cmd_id, cmd_data, cmd_len}), 64'({1'b1, 4'h0, 32'h1, 6'd12}));
`endif
        if (m_valid) accept_cmd();

        // ncs pulse with no sclk
        send_frame(128'h0, 0, 32'h0, 1'b0);
        chk("t6_empty_frame", 64'({cmd_valid, cmd_overflow}), 64'd0);

        // 40-bit and 66-bit frames keep the last 36 bits
        send_frame(128'hAB_CDEF_0123, 40, 32'h0, 1'b0);
`ifndef SPI_CMD_LEN_CHECK_EN
        chk("t6_long40", 64'({cmd_id, cmd_data, cmd_len}), 64'({4'h3, 32'hBCDEF012, 6'd40}));
`endif
        if (m_valid) accept_cmd();
        send_frame({62'd0, 30'h2AAAAAAA, 36'h9_8765_4321}, 66, 32'h0, 1'b0);
`ifndef SPI_CMD_LEN_CHECK_EN
        chk("len_saturate", 64'({cmd_id, cmd_data, cmd_len}), 64'({4'h1, 32'h98765432, 6'd63}));
`endif
        if (m_valid) accept_cmd();

        // reset in the middle of a frame, released while ncs still low
        @(negedge clk);
        ncs = 1'b0;
        wclk(6);
        for (int i = 0; i < 10; i++) clock_bit(1'b1, dummy);
        chk_en = 1'b0;
        nreset = 1'b0;
        m_valid = 1'b0;
        wclk(3);
        chk("t5_valid_in_reset", 64'(cmd_valid), 64'd0);
        nreset = 1'b1;
        for (int i = 0; i < 10; i++) clock_bit(i[0], dummy);
        wclk(HP);
        ncs = 1'b1;
        wclk(12);
        chk_en = 1'b1;
        chk("t5_not_delivered", 64'({cmd_valid, 6'(ovf_seen)}), 64'({1'b0, 6'(exp_ovf)}));
        send_frame(128'hC_AFEF_00D1, 36, 32'h0, 1'b0);
        chk("t5_next_frame", 64'({cmd_valid, cmd_id, cmd_data, cmd_len}), 64'({1'b1, 4'h1, 32'hCAFEF00D, 6'd36}));
        accept_cmd();
        wclk(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
